// File: rtl/race_ranker_pkg.sv
// rtl/race_ranker_pkg.sv - shared state encodings and lane count for the race ranker
package race_ranker_pkg;

  localparam int N_LANES = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/race_ranker_rank_assign.sv
// rtl/race_ranker_rank_assign.sv - combinational rank allocation for newly finished and force-ranked lanes
import race_ranker_pkg::*;

module rank_assign (
  input  logic [N_LANES-1:0]      new_mask,
  input  logic [N_LANES-1:0]      rank_mask,
  input  logic [2:0]              next_rank,
  input  logic                    force_en,
  output logic [N_LANES-1:0]      wr_en,
  output logic [N_LANES-1:0][1:0] rank_val,
  output logic [2:0]              add_cnt
);

  logic [2:0] r;

  always_comb begin
    r        = next_rank;
    wr_en    = '0;
    rank_val = '0;
    // Finishers take ranks first; force-ranked stragglers follow in lane order.
    for (int i = 0; i < N_LANES; i++) begin
      if (new_mask[i] && !rank_mask[i]) begin
        wr_en[i]    = 1'b1;
        rank_val[i] = r[1:0];
        r           = r + 3'd1;
      end
    end
    if (force_en) begin
      for (int i = 0; i < N_LANES; i++) begin
        if (!rank_mask[i] && !wr_en[i]) begin
          wr_en[i]    = 1'b1;
          rank_val[i] = r[1:0];
          r           = r + 3'd1;
        end
      end
    end
    add_cnt = r - next_rank;
  end

endmodule

// File: rtl/race_ranker.sv
// rtl/race_ranker.sv - finish-order capture FSM producing a rank permutation for four lanes
import race_ranker_pkg::*;

module race_ranker #(
  parameter int TIMEOUT = 1000,
  parameter int CW      = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [N_LANES-1:0]  lane_done,
  output logic [1:0]          N0,
  output logic [1:0]          N1,
  output logic [1:0]          N2,
  output logic [1:0]          N3,
  output logic [N_LANES-1:0]  rank_mask,
  output logic                ranks_valid,
  output logic                timed_out,
  output logic                busy
);

  state_t                   state;
  logic [N_LANES-1:0]       prev;
  logic [CW-1:0]            cnt;
  logic [2:0]               next_rank;
  logic [N_LANES-1:0][1:0]  ranks;

  logic [N_LANES-1:0]       rise;
  logic [N_LANES-1:0]       new_mask;
  logic [N_LANES-1:0]       next_mask;
  logic                     timeout_hit;
  logic                     force_en;
  logic [N_LANES-1:0]       wr_en;
  logic [N_LANES-1:0][1:0]  rank_val;
  logic [2:0]               add_cnt;

  assign rise        = lane_done & ~prev;
  assign new_mask    = rise & ~rank_mask;
  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));
  // Force only when lanes would still be missing after this cycle's finishers.
  assign force_en    = (state == ST_RUN) && timeout_hit && ((rank_mask | new_mask) != 4'hf);
  assign next_mask   = rank_mask | wr_en;

  rank_assign u_assign (
    .new_mask  (new_mask),
    .rank_mask (rank_mask),
    .next_rank (next_rank),
    .force_en  (force_en),
    .wr_en     (wr_en),
    .rank_val  (rank_val),
    .add_cnt   (add_cnt)
  );

  assign N0 = ranks[0];
  assign N1 = ranks[1];
  assign N2 = ranks[2];
  assign N3 = ranks[3];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      prev        <= '0;
      cnt         <= '0;
      next_rank   <= '0;
      ranks       <= '0;
      rank_mask   <= '0;
      ranks_valid <= 1'b0;
      timed_out   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      prev <= lane_done;
      if (start) begin
        state       <= ST_RUN;
        cnt         <= '0;
        next_rank   <= '0;
        ranks       <= '0;
        rank_mask   <= '0;
        ranks_valid <= 1'b0;
        timed_out   <= 1'b0;
        busy        <= 1'b1;
      end else if (state == ST_RUN) begin
        cnt <= cnt + CW'(1);
        for (int i = 0; i < N_LANES; i++) begin
          if (wr_en[i]) ranks[i] <= rank_val[i];
        end
        rank_mask <= next_mask;
        next_rank <= next_rank + add_cnt;
        if (next_mask == 4'hf) begin
          state       <= ST_DONE;
          busy        <= 1'b0;
          ranks_valid <= 1'b1;
          timed_out   <= force_en;
        end
      end
    end
  end

endmodule

// File: tb/tb_race_ranker.sv
// tb/tb_race_ranker.sv - directed self-checking bench for race_ranker
module tb_race_ranker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] lane_done;
  logic [1:0] N0, N1, N2, N3;
  logic [3:0] rank_mask;
  logic       ranks_valid, timed_out, busy;
  logic [7:0] word;
  logic [3:0] seen;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  race_ranker #(.TIMEOUT(20), .CW(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .lane_done   (lane_done),
    .N0          (N0),
    .N1          (N1),
    .N2          (N2),
    .N3          (N3),
    .rank_mask   (rank_mask),
    .ranks_valid (ranks_valid),
    .timed_out   (timed_out),
    .busy        (busy)
  );

  assign word = {N3, N2, N1, N0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; lane_done = 4'b0000;
    tick(); tick();
    rst = 1'b0;
    tests++; if (word !== 8'h00) begin fails++; $display("FAIL reset_word got %b want %b", word, 8'h00); end
    tests++; if (rank_mask !== 4'b0000) begin fails++; $display("FAIL reset_mask got %b want 0000", rank_mask); end
    tests++; if ({ranks_valid, timed_out, busy} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b want 000", {ranks_valid, timed_out, busy}); end
  endtask

  task automatic test_order();
    start = 1'b1; tick(); start = 1'b0;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL order_busy got %b want 1", busy); end
    lane_done = 4'b0100; tick();
    tests++; if (rank_mask !== 4'b0100 || N2 !== 2'd0) begin fails++; $display("FAIL order_first got mask %b N2 %0d want 0100 0", rank_mask, N2); end
    lane_done = 4'b0101; tick();
    lane_done = 4'b1101; tick();
    tests++; if (ranks_valid !== 1'b0) begin fails++; $display("FAIL order_early_valid got %b want 0", ranks_valid); end
    lane_done = 4'b1111; tick();
    tests++; if (word !== 8'b10_00_11_01) begin fails++; $display("FAIL order_word got %b want %b", word, 8'b10_00_11_01); end
    tests++; if ({ranks_valid, timed_out, busy} !== 3'b100) begin fails++; $display("FAIL order_flags got %b want 100", {ranks_valid, timed_out, busy}); end
    seen = (4'b1 << N0) | (4'b1 << N1) | (4'b1 << N2) | (4'b1 << N3);
    tests++; if (seen !== 4'b1111) begin fails++; $display("FAIL order_perm got %b want 1111", seen); end
    lane_done = 4'b0000; tick();
  endtask

  task automatic test_simultaneous();
    start = 1'b1; tick(); start = 1'b0;
    lane_done = 4'b1010; tick();
    tests++; if (rank_mask !== 4'b1010 || N1 !== 2'd0 || N3 !== 2'd1) begin fails++; $display("FAIL simul_pair got mask %b N1 %0d N3 %0d want 1010 0 1", rank_mask, N1, N3); end
    lane_done = 4'b1011; tick();
    lane_done = 4'b1111; tick();
    tests++; if (word !== 8'b01_11_00_10) begin fails++; $display("FAIL simul_word got %b want %b", word, 8'b01_11_00_10); end
    tests++; if (ranks_valid !== 1'b1) begin fails++; $display("FAIL simul_valid got %b want 1", ranks_valid); end
    lane_done = 4'b0000; tick();
  endtask

  task automatic test_timeout();
    start = 1'b1; tick(); start = 1'b0;
    lane_done = 4'b1000; tick();
    repeat (18) tick();
    tests++; if ({ranks_valid, busy} !== 2'b01 || rank_mask !== 4'b1000) begin fails++; $display("FAIL timeout_before got valid/busy %b mask %b want 01 1000", {ranks_valid, busy}, rank_mask); end
    tick();
    tests++; if (word !== 8'b00_11_10_01) begin fails++; $display("FAIL timeout_word got %b want %b", word, 8'b00_11_10_01); end
    tests++; if ({ranks_valid, timed_out, busy} !== 3'b110) begin fails++; $display("FAIL timeout_flags got %b want 110", {ranks_valid, timed_out, busy}); end
    lane_done = 4'b0000; tick();
  endtask

  task automatic test_finish_at_timeout();
    start = 1'b1; tick(); start = 1'b0;
    lane_done = 4'b0111; tick();
    repeat (18) tick();
    lane_done = 4'b1111; tick();
    tests++; if (word !== 8'b11_10_01_00 || {ranks_valid, timed_out} !== 2'b10) begin fails++; $display("FAIL edge_all got word %b valid/to %b want 11100100 10", word, {ranks_valid, timed_out}); end
    lane_done = 4'b0000; tick();
    start = 1'b1; tick(); start = 1'b0;
    lane_done = 4'b0010; tick();
    repeat (18) tick();
    lane_done = 4'b0110; tick();
    tests++; if (word !== 8'b11_01_00_10 || {ranks_valid, timed_out} !== 2'b11) begin fails++; $display("FAIL edge_mixed got word %b valid/to %b want 11010010 11", word, {ranks_valid, timed_out}); end
    lane_done = 4'b0000; tick();
  endtask

  task automatic test_retrigger();
    lane_done = 4'b0001; tick();
    start = 1'b1; tick(); start = 1'b0;
    lane_done = 4'b0101; tick();
    tests++; if (rank_mask !== 4'b0100 || N2 !== 2'd0) begin fails++; $display("FAIL retrig_held got mask %b N2 %0d want 0100 0", rank_mask, N2); end
    lane_done = 4'b0001; tick();
    lane_done = 4'b0101; tick();
    tests++; if (rank_mask !== 4'b0100 || N2 !== 2'd0) begin fails++; $display("FAIL retrig_pulse got mask %b N2 %0d want 0100 0", rank_mask, N2); end
    lane_done = 4'b0100; tick();
    lane_done = 4'b0101; tick();
    tests++; if (rank_mask !== 4'b0101 || N0 !== 2'd1) begin fails++; $display("FAIL retrig_rerise got mask %b N0 %0d want 0101 1", rank_mask, N0); end
  endtask

  task automatic test_restart();
    start = 1'b1; lane_done = 4'b0000; tick(); start = 1'b0;
    tests++; if (rank_mask !== 4'b0000 || word !== 8'h00) begin fails++; $display("FAIL restart_clear got mask %b word %b want 0000 00000000", rank_mask, word); end
    tests++; if ({ranks_valid, busy} !== 2'b01) begin fails++; $display("FAIL restart_flags got %b want 01", {ranks_valid, busy}); end
    lane_done = 4'b1111; tick();
    tests++; if (word !== 8'b11_10_01_00 || ranks_valid !== 1'b1) begin fails++; $display("FAIL restart_fresh got word %b valid %b want 11100100 1", word, ranks_valid); end
  endtask

  task automatic test_rst_done();
    lane_done = 4'b0000;
    rst = 1'b1; start = 1'b1; tick(); rst = 1'b0; start = 1'b0;
    tests++; if (word !== 8'h00 || rank_mask !== 4'b0000 || {ranks_valid, timed_out, busy} !== 3'b000) begin fails++; $display("FAIL rst_done got word %b mask %b flags %b want 0 0 000", word, rank_mask, {ranks_valid, timed_out, busy}); end
    lane_done = 4'b1111; tick(); tick();
    tests++; if (rank_mask !== 4'b0000 || {ranks_valid, busy} !== 2'b00) begin fails++; $display("FAIL idle_edges got mask %b flags %b want 0000 00", rank_mask, {ranks_valid, busy}); end
    lane_done = 4'b0000; tick();
  endtask

  initial begin
    test_reset();
    test_order();
    test_simultaneous();
    test_timeout();
    test_finish_at_timeout();
    test_retrigger();
    test_restart();
    test_rst_done();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/race_ranker.md
# race_ranker

Sequential finish-order capture stage that sits directly upstream of `podium_permutations`. It watches four lane finish sensors after a start command and assigns each lane its finishing rank (0 = first … 3 = last). It presents the four 2-bit ranks as `N0..N3`, which wire straight into `podium_permutations`. The assignment rules guarantee that the `N0..N3` word is always a permutation of 0..3 when `ranks_valid` is high.

## Interface
- `TIMEOUT`, default 1000: cycles in RUN before unfinished lanes are force-ranked.
- `CW`, default 10: width of the timeout counter; must satisfy 2^CW > TIMEOUT.
- `clk`  in  1  single clock, all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins or restarts a race.
- `lane_done`  in  4  finish sensor per lane, level; a rising edge means finished.
- `N0`,`N1`,`N2`,`N3`  out  2 each  rank of lane 0..3.
- `rank_mask`  out  4  bit i set once lane i holds a rank.
- `ranks_valid`  out  1  all four lanes ranked; N0..N3 form a permutation.
- `timed_out`  out  1  set when ranking was completed by timeout.
- `busy`  out  1  high in RUN.

## Operation
- States:
  - **IDLE**: after reset.
  - **RUN**: entered from IDLE, DONE or RUN on `start`.
  - **DONE**: entered when `rank_mask` becomes 4'b1111.
- Edge detection:
  - `prev` register holds the last `lane_done`; it updates every cycle in all states.
  - `rise = lane_done & ~prev`.
  - A lane already high when `start` arrives counts only after it falls and rises again.
- In RUN:
  - Each cycle the set `new = rise & ~rank_mask` receives consecutive ranks starting at `next_rank`, in ascending lane index.
  - Example: lanes 1 and 3 finish together with `next_rank`=1, so lane 1 gets 1 and lane 3 gets 2.
  - `next_rank` advances by popcount(`new`). Use a 3-bit count internally so that reaching 4 is detectable.
- Re-triggers of an already-ranked lane are ignored.
- Rising edges in IDLE and DONE are ignored, apart from the `prev` update.
- Timeout:
  - The counter clears on `start` and increments every RUN cycle.
  - When it equals `TIMEOUT-1` and lanes remain unranked, all unranked lanes are ranked that cycle in ascending lane order after any `new` lanes from the same cycle.
  - That cycle also sets `timed_out` and moves to DONE.
- `start` while in RUN or DONE:
  - clears ranks, `rank_mask`, `next_rank`, `timed_out` and the counter, and re-enters RUN;
  - overrides any finish or timeout in the same cycle.
- Unranked lanes read `N`=0 and are qualified by `rank_mask`.

## Timing
- Reset values: `N0..N3`=0, `rank_mask`=0, `ranks_valid`=0, `timed_out`=0, `busy`=0, state IDLE, `prev`=0, counter 0.
- `start` sampled at edge t gives `busy`=1 from t+1.
- A `lane_done` rise visible before edge t gives the rank and `rank_mask` bit updated at t+1. Latency is 1 cycle.
- On the cycle the 4th lane is ranked (or the timeout fires):
  - DONE, `ranks_valid`=1 and `busy`=0 all appear at the next edge;
  - `ranks_valid` holds until `start` or `rst`.
- All four lanes rising in one cycle ranks them 0,1,2,3 in lane order and gives DONE next cycle.
- A simultaneous finish and timeout in the same cycle ranks the finishers first; `timed_out` is set only if force-ranking was actually needed.
- `rst` mid-race returns to IDLE at the next edge with reset values, overriding `start`.

## Structure
- Shared include `src/race_defs.vh`:
  - state encodings `ST_IDLE`=2'd0, `ST_RUN`=2'd1, `ST_DONE`=2'd2;
  - `N_LANES`=4.
- Sub-module `rank_assign`, purely combinational:
  - inputs: `new` mask, current `rank_mask`, `next_rank`, `force` (timeout);
  - outputs: per-lane rank write enables, rank values and the count added.
- `race_ranker` holds the FSM, edge detector, counter and registers.

## Test plan
- Reset, `start`, then lanes rise in order 2,0,3,1 on separate cycles:
  - gives N0=1, N1=3, N2=0, N3=2 and `ranks_valid` one cycle after lane 1;
  - `podium_permutations` VALID=1 on that word.
- `start`, then lanes 1 and 3 rise together, then lane 0, then lane 2 → N0=2, N1=0, N2=3, N3=1.
- `TIMEOUT`=20, only lane 3 finishes → at cycle 20 of RUN, N3=0, N0=1, N1=2, N2=3, `timed_out`=1.
- Lane 2 pulses twice, and lane 0 is high before `start` and held → lane 2 keeps its first rank and lane 0 stays unranked until it re-rises.
- `start` asserted mid-race after two lanes ranked → `rank_mask`=0, N0..N3=0 next cycle, and the race proceeds fresh.
- `rst` in DONE with `ranks_valid`=1 → all outputs 0 and state IDLE next cycle; edges in IDLE leave `rank_mask`=0.
